// File: rtl/aes_pkg.sv
// Shared AES constants, types and helpers used by the key schedule and the
// round datapath.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    // Key-length encoding presented on key_len.
    localparam logic [1:0] KEY128   = 2'd0;
    localparam logic [1:0] KEY192   = 2'd1;
    localparam logic [1:0] KEY256   = 2'd2;
    localparam logic [1:0] KEY_RSVD = 2'd3;

    // Words per key (Nk), rounds (Nr) and schedule length in words (Nw).
    localparam logic [3:0] NK128 = 4'd4;
    localparam logic [3:0] NK192 = 4'd6;
    localparam logic [3:0] NK256 = 4'd8;
    localparam logic [3:0] NR128 = 4'd10;
    localparam logic [3:0] NR192 = 4'd12;
    localparam logic [3:0] NR256 = 4'd14;
    localparam logic [5:0] NW128 = 6'd44;
    localparam logic [5:0] NW192 = 6'd52;
    localparam logic [5:0] NW256 = 6'd60;

    // Largest schedule and largest key, in words.
    localparam int NW_MAX  = 60;
    localparam int WIN_LEN = 8;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } ks_state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            KEY128:  return NK128;
            KEY192:  return NK192;
            KEY256:  return NK256;
            default: return NK128;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] len);
        case (len)
            KEY128:  return NR128;
            KEY192:  return NR192;
            KEY256:  return NR256;
            default: return NR128;
        endcase
    endfunction

    function automatic logic [5:0] nw_of(input logic [1:0] len);
        case (len)
            KEY128:  return NW128;
            KEY192:  return NW192;
            KEY256:  return NW256;
            default: return NW128;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational. Also used by the SubBytes stage.
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] result
);

    // Row-major table, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry k sits at bit offset (255-k)*8, i.e. {~k, 3'b000}.
    assign result = SBOX_TABLE[{~value, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: loads a 128/192/256-bit key, generates one
// schedule word per clock and then serves round keys on a combinational port.
module aes_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_out,
    output logic [3:0]   num_rounds,
    output logic         busy,
    output logic         ready,
    output logic         done
);

    ks_state_t state, state_next;

    word_t       w_mem [NW_MAX];
    word_t       win   [WIN_LEN];

    logic [5:0]  idx;
    logic [2:0]  mod_cnt;
    logic [3:0]  nk_q;
    logic [3:0]  nr_q;
    logic [5:0]  nw_q;
    logic [7:0]  rcon;
    logic [3:0]  num_rounds_q;
    logic        done_q;

    logic        start_ok;
    logic        load;
    logic        last;
    logic        rot_step;
    logic        sub_step;
    logic [2:0]  back_idx;
    word_t       prev_word;
    word_t       sub_in;
    word_t       sub_out;
    word_t       temp_word;
    word_t       new_word;
    logic [3:0]  nk_ld;
    logic [8:0]  key_shift;
    logic [255:0] key_aligned;
    block_t      rk_word;

    assign start_ok = start && (key_len != KEY_RSVD);
    assign last     = (state == EXPAND) && (idx == nw_q - 6'd1);

    // The window keeps the newest word in slot 7, so w[i-Nk] is slot 8-Nk.
    assign back_idx  = 3'(4'd8 - nk_q);
    assign prev_word = win[WIN_LEN-1];
    assign rot_step  = (mod_cnt == 3'd0);
    assign sub_step  = (nk_q == NK256) && (mod_cnt == 3'd4);
    assign sub_in    = rot_step ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_subword
            aes_sbox u_sbox (
                .value  (sub_in[8*b +: 8]),
                .result (sub_out[8*b +: 8])
            );
        end
    endgenerate

    assign temp_word = rot_step ? (sub_out ^ {rcon, 24'h000000}) :
                       sub_step ? sub_out : prev_word;
    assign new_word  = win[back_idx] ^ temp_word;

    // Left-justify the incoming key so word k is always at a fixed offset.
    assign nk_ld       = nk_of(key_len);
    assign key_shift   = {4'd8 - nk_ld, 5'd0};
    assign key_aligned = key_in << key_shift;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs; start is only honoured when idle or ready.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        ready      = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    load       = 1'b1;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                busy = 1'b1;
                if (last) begin
                    state_next = READY;
                end
            end
            READY: begin
                ready = 1'b1;
                if (start_ok) begin
                    load       = 1'b1;
                    state_next = EXPAND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Word index, Nk wrap counter, Rcon and the latched key geometry.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= 6'd0;
            mod_cnt      <= 3'd0;
            nk_q         <= NK128;
            nr_q         <= NR128;
            nw_q         <= NW128;
            rcon         <= 8'h01;
            num_rounds_q <= 4'd0;
            done_q       <= 1'b0;
        end else begin
            done_q <= last;
            if (load) begin
                idx     <= {2'b00, nk_ld};
                mod_cnt <= 3'd0;
                nk_q    <= nk_ld;
                nr_q    <= nr_of(key_len);
                nw_q    <= nw_of(key_len);
                rcon    <= 8'h01;
            end else if (state == EXPAND) begin
                idx     <= idx + 6'd1;
                mod_cnt <= ({1'b0, mod_cnt} == nk_q - 4'd1) ? 3'd0 : mod_cnt + 3'd1;
                if (rot_step) begin
                    rcon <= xtime(rcon);
                end
                if (last) begin
                    num_rounds_q <= nr_q;
                end
            end
        end
    end

    // Schedule storage and sliding window; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (!reset && load) begin
            for (int j = 0; j < WIN_LEN; j++) begin
                win[j] <= key_in[32*(7-j) +: 32];
            end
            for (int k = 0; k < WIN_LEN; k++) begin
                if (4'(k) < nk_ld) begin
                    w_mem[k] <= key_aligned[255-32*k -: 32];
                end
            end
        end else if (!reset && state == EXPAND) begin
            for (int j = 0; j < WIN_LEN-1; j++) begin
                win[j] <= win[j+1];
            end
            win[WIN_LEN-1] <= new_word;
            w_mem[idx]     <= new_word;
        end
    end

    // Zero-latency round-key read, blanked unless the schedule is valid and r <= Nr.
    always_comb begin
        rk_word = '0;
        if (state == READY && rk_addr <= num_rounds_q) begin
            rk_word = {w_mem[{rk_addr, 2'b00}], w_mem[{rk_addr, 2'b01}],
                       w_mem[{rk_addr, 2'b10}], w_mem[{rk_addr, 2'b11}]};
        end
    end

    assign rk_out     = rk_word;
    assign num_rounds = num_rounds_q;
    assign done       = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Randomised scoreboard bench for aes_key_expand with an independent
// FIPS-197 reference model (S-box derived from GF(2^8) inversion).
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] key_in = '0;
    logic [3:0]   rk_addr = 4'd0;
    logic [127:0] rk_out;
    logic [3:0]   num_rounds;
    logic         busy;
    logic         ready;
    logic         done;

    aes_key_expand dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_len    (key_len),
        .key_in     (key_in),
        .rk_addr    (rk_addr),
        .rk_out     (rk_out),
        .num_rounds (num_rounds),
        .busy       (busy),
        .ready      (ready),
        .done       (done)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors  = 0;
    int checks  = 0;
    int issued  = 0;
    int checked = 0;
    int last_start_edge = 0;

    logic [7:0] sbm [256];

    typedef struct {
        int             start_edge;
        int             latency;
        logic [3:0]     nr;
        logic [15:0][127:0] rk;
        int             kat_n;
        logic [3:0]     kat_a0;
        logic [127:0]   kat_v0;
        logic [3:0]     kat_a1;
        logic [127:0]   kat_v1;
    } exp_t;

    exp_t sb [$];

    localparam logic [255:0] FIPS128 = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    localparam logic [255:0] FIPS192 = {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
    localparam logic [255:0] FIPS256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] bb = b_in;
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ a;
            a  = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    // Multiplicative inverse (a^254) followed by the FIPS-197 affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int k = 0; k < 254; k++) inv = gmul(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbm[x[31:24]], sbm[x[23:16]], sbm[x[15:8]], sbm[x[7:0]]};
    endfunction

    // Straight textbook key expansion; returns round key r, or 0 past Nr.
    function automatic logic [127:0] model_rk(input logic [255:0] key, input int len, input int r);
        int nk = 4 + 2*len;
        int nr = nk + 6;
        int nw = 4*(nr + 1);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        if (r > nr) return '0;
        for (int k = 0; k < nk; k++) w[k] = key[32*(nk-1-k) +: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int m = 1; m < i/nk; m++) rc = gmul(rc, 8'h02);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
        return k;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [255:0] key, input logic [1:0] len, input int kat_n,
                                 input logic [3:0] a0, input logic [127:0] v0,
                                 input logic [3:0] a1, input logic [127:0] v1);
        exp_t e;
        logic was_ready;
        int nk;
        @(negedge clk);
        was_ready = ready;
        key_in  = key;
        key_len = len;
        start   = 1'b1;
        @(posedge clk);
        if (len != 2'd3) begin
            nk = 4 + 2*int'(len);
            e.start_edge = cyc;
            e.latency    = 4*(nk + 7) - nk + 1;
            e.nr         = 4'(nk + 6);
            for (int r = 0; r < 16; r++) e.rk[r] = model_rk(key, int'(len), r);
            e.kat_n  = kat_n;
            e.kat_a0 = a0;
            e.kat_v0 = v0;
            e.kat_a1 = a1;
            e.kat_v1 = v1;
            sb.push_back(e);
            issued++;
            last_start_edge = cyc;
        end
        @(negedge clk);
        start = 1'b0;
        if (len != 2'd3) begin
            checkOutput("busy_after_start", busy, 1'b1);
            checkOutput("ready_after_start", ready, 1'b0);
        end else begin
            checkOutput("busy_reserved_len", busy, 1'b0);
            checkOutput("ready_reserved_len", ready, was_ready);
        end
    endtask

    task automatic waitChecked();
        int n = 0;
        while (checked != issued && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("expansion_completed", checked, issued);
    endtask

    // Monitor: pops one expectation per done pulse and sweeps every rk_addr.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pending expansion", cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput("done_latency", cyc - e.start_edge, e.latency);
                    checkOutput("num_rounds", num_rounds, e.nr);
                    checkOutput("busy_at_done", busy, 1'b0);
                    checkOutput("ready_at_done", ready, 1'b1);
                    for (int r = 0; r < 16; r++) begin
                        rk_addr = 4'(r);
                        #1;
                        checkOutput($sformatf("rk_out[%0d]", r), rk_out, e.rk[r]);
                        if (e.kat_n > 0 && r == int'(e.kat_a0))
                            checkOutput($sformatf("known_answer[%0d]", r), rk_out, e.kat_v0);
                        if (e.kat_n > 1 && r == int'(e.kat_a1))
                            checkOutput($sformatf("known_answer[%0d]", r), rk_out, e.kat_v1);
                    end
                    @(negedge clk);
                    checkOutput("done_one_cycle", done, 1'b0);
                    checked++;
                end
            end
        end
    end

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by random keys.
    initial begin
        for (int k = 0; k < 256; k++) sbm[k] = sbox_ref(8'(k));

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_ready", ready, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_num_rounds", num_rounds, 4'd0);
        checkOutput("reset_rk_out", rk_out, '0);
        reset = 1'b0;

        // Reserved key length from IDLE.
        applyStimulus(rand_key(), 2'd3, 0, 4'd0, '0, 4'd0, '0);
        @(negedge clk);
        checkOutput("idle_after_reserved", busy, 1'b0);

        applyStimulus(FIPS128, 2'd0, 2, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605,
                      4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        waitChecked();

        applyStimulus(FIPS192, 2'd1, 1, 4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d, 4'd0, '0);
        waitChecked();

        applyStimulus(FIPS256, 2'd2, 2, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, 4'd15, '0);
        waitChecked();

        // Reserved key length from READY keeps the schedule.
        applyStimulus(rand_key(), 2'd3, 0, 4'd0, '0, 4'd0, '0);

        // Second start at cycle 20 of an AES-128 run must be ignored.
        applyStimulus(FIPS128, 2'd0, 1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd0, '0);
        while (cyc - last_start_edge < 20) @(negedge clk);
        key_in  = rand_key();
        key_len = 2'd2;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        waitChecked();

        // Reset at cycle 30 of an expansion.
        applyStimulus(rand_key(), 2'd0, 0, 4'd0, '0, 4'd0, '0);
        while (cyc - last_start_edge < 30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_busy", busy, 1'b0);
        checkOutput("midreset_ready", ready, 1'b0);
        checkOutput("midreset_done", done, 1'b0);
        checkOutput("midreset_num_rounds", num_rounds, 4'd0);
        checkOutput("midreset_rk_out", rk_out, '0);
        reset = 1'b0;
        sb.delete();
        issued = checked;
        @(negedge clk);
        checkOutput("midreset_stays_idle", busy, 1'b0);

        applyStimulus(FIPS128, 2'd0, 1, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 4'd0, '0);
        waitChecked();

        // Restart from READY with a different key and length.
        applyStimulus(FIPS256, 2'd2, 1, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, 4'd0, '0);
        waitChecked();

        for (int n = 0; n < 6; n++) begin
            applyStimulus(rand_key(), 2'($urandom_range(0, 2)), 0, 4'd0, '0, 4'd0, '0);
            waitChecked();
        end

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
